// File: rtl/uart_baud_ctrl_if.sv
// rtl/uart_baud_ctrl_if.sv - register-file side bundle of the baud-rate sequencer
interface uart_baud_ctrl_if #(
    parameter int CNT_W = 24
);
    logic             cfg_wr;
    logic [15:0]      cfg_wdata;
    logic             ab_start;
    logic             baud_en;
    logic [15:0]      divisor;
    logic             ab_busy;
    logic             ab_done;
    logic             ab_err;
    logic [1:0]       ab_err_code;
    logic [CNT_W-1:0] measured;

    modport master (
        output cfg_wr, cfg_wdata, ab_start,
        input  baud_en, divisor, ab_busy, ab_done, ab_err, ab_err_code, measured
    );

    modport slave (
        input  cfg_wr, cfg_wdata, ab_start,
        output baud_en, divisor, ab_busy, ab_done, ab_err, ab_err_code, measured
    );
endinterface

// File: rtl/uart_baud_ctrl.sv
// rtl/uart_baud_ctrl.sv - baud generator divisor owner with manual load and auto-baud
module uart_baud_ctrl #(
    parameter int OVS_LOG2  = 4,
    parameter int CNT_W     = 24,
    parameter int MIN_PULSE = 8,
    parameter int MAX_CNT   = 2**24-1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    uart_baud_ctrl_if.slave   bus
);
    localparam int               SHIFT = OVS_LOG2 + 1;
    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_CNT);
    localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_PULSE);
    localparam logic [CNT_W:0]   ROUND = (CNT_W+1)'(2**(SHIFT-1));
    localparam logic [CNT_W-1:0] Q_MAX = CNT_W'(65536);

    typedef enum logic [2:0] {IDLE, WAIT_FALL, MEASURE, CALC, QUIESCE0, QUIESCE1} state_t;

    state_t           state_q, state_d;
    logic             rx_m_q, rx_s_q;
    logic [CNT_W-1:0] wait_q, wait_d, cnt_q, cnt_d, measured_q, measured_d;
    logic [15:0]      pend_q, pend_d, divisor_q, divisor_d;
    logic             auto_q, auto_d, baud_en_q, baud_en_d, busy_q, busy_d;
    logic             done_q, done_d, err_q, err_d;
    logic [1:0]       code_q, code_d;

    logic [CNT_W-1:0] wait_inc, cnt_inc, q;
    logic [CNT_W:0]   sum;

    assign wait_inc = (wait_q == MAX_C) ? wait_q : wait_q + 1'b1;
    assign cnt_inc  = (cnt_q == MAX_C) ? cnt_q : cnt_q + 1'b1;
    // One extra bit keeps the rounding add from overflowing near the top of the range.
    assign sum      = {1'b0, measured_q} + ROUND;
    assign q        = CNT_W'(sum >> SHIFT);

    always_comb begin
        state_d    = state_q;
        wait_d     = wait_q;
        cnt_d      = cnt_q;
        measured_d = measured_q;
        pend_d     = pend_q;
        divisor_d  = divisor_q;
        auto_d     = auto_q;
        baud_en_d  = baud_en_q;
        busy_d     = busy_q;
        code_d     = code_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.cfg_wr) begin
                    pend_d    = bus.cfg_wdata;
                    auto_d    = 1'b0;
                    busy_d    = 1'b1;
                    baud_en_d = 1'b0;
                    state_d   = QUIESCE0;
                end else if (bus.ab_start) begin
                    code_d  = 2'd0;
                    wait_d  = '0;
                    auto_d  = 1'b1;
                    busy_d  = 1'b1;
                    state_d = WAIT_FALL;
                end
            end
            WAIT_FALL: begin
                wait_d = wait_inc;
                if (!rx_s_q) begin
                    cnt_d   = CNT_W'(1);
                    state_d = MEASURE;
                end else if (wait_inc == MAX_C) begin
                    err_d   = 1'b1;
                    code_d  = 2'd1;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end
            end
            MEASURE: begin
                if (!rx_s_q) begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == MAX_C) begin
                        err_d   = 1'b1;
                        code_d  = 2'd2;
                        busy_d  = 1'b0;
                        state_d = IDLE;
                    end
                end else if (cnt_q < MIN_C) begin
                    // Glitch: resume waiting; the wait budget keeps running.
                    state_d = WAIT_FALL;
                end else begin
                    measured_d = cnt_q;
                    state_d    = CALC;
                end
            end
            CALC: begin
                if (q < CNT_W'(2) || q > Q_MAX) begin
                    err_d   = 1'b1;
                    code_d  = 2'd3;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    pend_d    = 16'(q - 1'b1);
                    baud_en_d = 1'b0;
                    state_d   = QUIESCE0;
                end
            end
            QUIESCE0: begin
                divisor_d = pend_q;
                state_d   = QUIESCE1;
            end
            QUIESCE1: begin
                baud_en_d = (pend_q != 16'd0);
                busy_d    = 1'b0;
                done_d    = auto_q;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            rx_m_q     <= 1'b1;
            rx_s_q     <= 1'b1;
            wait_q     <= '0;
            cnt_q      <= '0;
            measured_q <= '0;
            pend_q     <= '0;
            divisor_q  <= '0;
            auto_q     <= 1'b0;
            baud_en_q  <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= '0;
        end else begin
            state_q    <= state_d;
            rx_m_q     <= rx;
            rx_s_q     <= rx_m_q;
            wait_q     <= wait_d;
            cnt_q      <= cnt_d;
            measured_q <= measured_d;
            pend_q     <= pend_d;
            divisor_q  <= divisor_d;
            auto_q     <= auto_d;
            baud_en_q  <= baud_en_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            code_q     <= code_d;
        end
    end

    assign bus.baud_en     = baud_en_q;
    assign bus.divisor     = divisor_q;
    assign bus.ab_busy     = busy_q;
    assign bus.ab_done     = done_q;
    assign bus.ab_err      = err_q;
    assign bus.ab_err_code = code_q;
    assign bus.measured    = measured_q;
endmodule
